// File: rtl/vec3_sub_arbiter_pkg.sv
`default_nettype none
//==============================================================================
// vec3_sub_arbiter_pkg: shared vector type, DSP usage selector, fp32_sub latency.
// Rev 1.0
//==============================================================================
package vec3_sub_arbiter_pkg;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
    } vec3_t;

    typedef enum logic [1:0] {
        LOW  = 2'd0,
        MED  = 2'd1,
        HIGH = 2'd2
    } use_dsp_e;

    localparam int CNT_W = 4;

    function automatic int fp32_sub_latency(input use_dsp_e dsp);
        case (dsp)
            LOW:     return 10;
            MED:     return 8;
            default: return 6;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp32_sub.sv
`default_nettype none
//==============================================================================
// fp32_sub: pipelined fp32 a-b, flush-to-zero, truncating; no reset on datapath.
// Rev 1.0
//==============================================================================
module fp32_sub #(
    parameter int LATENCY = 8
) (
    input  logic        clk,
    input  logic        op_vld_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        result_vld_o,
    output logic [31:0] result_o
);

    logic [31:0] bn, big, sml, res_w;
    logic        swap;
    logic [23:0] mb, ms;
    logic [7:0]  d;
    logic [26:0] al;
    logic [27:0] sum, norm;
    int          p, e;

    always_comb begin
        bn   = {~b_i[31], b_i[30:0]};
        swap = bn[30:0] > a_i[30:0];
        big  = swap ? bn  : a_i;
        sml  = swap ? a_i : bn;
        mb   = (big[30:23] != 8'd0) ? {1'b1, big[22:0]} : 24'd0;
        ms   = (sml[30:23] != 8'd0) ? {1'b1, sml[22:0]} : 24'd0;
        d    = big[30:23] - sml[30:23];
        al   = (d > 8'd26) ? 27'd0 : ({ms, 3'b000} >> d);
        if (big[31] == sml[31]) begin
            sum = {1'b0, mb, 3'b000} + {1'b0, al};
        end else begin
            sum = {1'b0, mb, 3'b000} - {1'b0, al};
        end
        p = -1;
        for (int i = 0; i < 28; i++) begin
            if (sum[i]) p = i;
        end
        e    = int'(big[30:23]) + p - 26;
        norm = (p >= 26) ? (sum >> (p - 26)) : (sum << (26 - p));
        res_w = {big[31], e[7:0], norm[25:3]};
        // Exact cancellation always yields +0.
        if (p < 0 || e <= 0) begin
            res_w = 32'd0;
        end else if (e >= 255) begin
            res_w = {big[31], 8'hFF, 23'd0};
        end
    end

    logic [32:0] pipe_q [LATENCY];

    always_ff @(posedge clk) begin
        pipe_q[0] <= {op_vld_i, res_w};
        for (int s = 1; s < LATENCY; s++) begin
            pipe_q[s] <= pipe_q[s-1];
        end
    end

    assign {result_vld_o, result_o} = pipe_q[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/vec3_sub.sv
`default_nettype none
//==============================================================================
// vec3_sub: three parallel fp32_sub lanes computing a - b per component.
// Rev 1.0
//==============================================================================
module vec3_sub
    import vec3_sub_arbiter_pkg::*;
#(
    parameter use_dsp_e USE_DSP = MED
) (
    input  logic  clk,
    input  logic  op_vld_i,
    input  vec3_t a_i,
    input  vec3_t b_i,
    output logic  result_vld_o,
    output vec3_t result_o
);

    localparam int LAT = fp32_sub_latency(USE_DSP);

    logic [2:0]  lane_vld;
    logic [95:0] lane_res;

    for (genvar l = 0; l < 3; l++) begin : g_lane
        fp32_sub #(.LATENCY(LAT)) u_lane (
            .clk          (clk),
            .op_vld_i     (op_vld_i),
            .a_i          (a_i[32*l +: 32]),
            .b_i          (b_i[32*l +: 32]),
            .result_vld_o (lane_vld[l]),
            .result_o     (lane_res[32*l +: 32])
        );
    end

    assign result_vld_o = &lane_vld;
    assign result_o     = lane_res;

endmodule
`default_nettype wire

// File: rtl/vec3_sub_arbiter_rr_arbiter.sv
`default_nettype none
//==============================================================================
// rr_arbiter: one-hot round-robin grant starting at ptr, wrapping modulo N.
// Rev 1.0
//==============================================================================
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         eligible_i,
    input  logic                 advance_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] ptr_o
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr_q, ptr_d, idx;
    logic [N-1:0]  gnt_w;
    logic          found;

    always_comb begin
        gnt_w = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < N; off++) begin
            idx = PW'((int'(ptr_q) + off) % N);
            if (!found && eligible_i[idx]) begin
                found      = 1'b1;
                gnt_w[idx] = 1'b1;
                ptr_d      = PW'((int'(idx) + 1) % N);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance_i && found) begin
            ptr_q <= ptr_d;
        end
    end

    assign gnt_o = gnt_w;
    assign ptr_o = ptr_q;

endmodule
`default_nettype wire

// File: rtl/vec3_sub_arbiter.sv
`default_nettype none
//==============================================================================
// vec3_sub_arbiter: round-robin sharing of one vec3_sub among NUM_REQ requesters.
// Rev 1.0
//==============================================================================
module vec3_sub_arbiter
    import vec3_sub_arbiter_pkg::*;
#(
    parameter int       NUM_REQ         = 4,
    parameter use_dsp_e USE_DSP         = MED,
    parameter int       SUB_LATENCY     = fp32_sub_latency(USE_DSP),
    parameter int       MAX_OUTSTANDING = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_vld,
    input  vec3_t [NUM_REQ-1:0]  req_a,
    input  vec3_t [NUM_REQ-1:0]  req_b,
    output logic [NUM_REQ-1:0]   req_gnt,
    output logic [NUM_REQ-1:0]   rsp_vld,
    output vec3_t                rsp_result,
    output logic                 busy,
    output logic                 err_tag
);

    localparam int IDW   = $clog2(NUM_REQ);
    localparam int ARM_W = $clog2(SUB_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } arb_tag_t;

    logic                 live_q;
    logic [CNT_W-1:0]     cnt_q [NUM_REQ];
    logic [CNT_W-1:0]     cnt_d [NUM_REQ];
    logic [NUM_REQ-1:0]   elig;
    logic [IDW-1:0]       gnt_id;
    logic [IDW-1:0]       rr_ptr_unused;
    logic                 iss_vld_q;
    logic [IDW-1:0]       iss_id_q;
    vec3_t                iss_a_q, iss_b_q;
    logic                 sub_res_vld;
    vec3_t                sub_res;
    arb_tag_t             tag_q [SUB_LATENCY];
    arb_tag_t             tag_tail;
    logic [NUM_REQ-1:0]   rsp_vld_q;
    vec3_t                rsp_res_q;
    logic [ARM_W-1:0]     arm_q;
    logic                 err_q;
    logic                 busy_w;

    // No grants during reset or in the first cycle after it.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_vld[i] && (cnt_q[i] < CNT_MAX) && live_q && !rst;
        end
    end

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk        (clk),
        .rst        (rst),
        .eligible_i (elig),
        .advance_i  (live_q),
        .gnt_o      (req_gnt),
        .ptr_o      (rr_ptr_unused)
    );

    always_comb begin
        gnt_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_gnt[i]) gnt_id = IDW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live_q    <= 1'b0;
            iss_vld_q <= 1'b0;
            iss_id_q  <= '0;
            iss_a_q   <= '0;
            iss_b_q   <= '0;
        end else begin
            live_q    <= 1'b1;
            iss_vld_q <= |req_gnt;
            if (|req_gnt) begin
                iss_id_q <= gnt_id;
                iss_a_q  <= req_a[gnt_id];
                iss_b_q  <= req_b[gnt_id];
            end
        end
    end

    vec3_sub #(.USE_DSP(USE_DSP)) u_sub (
        .clk          (clk),
        .op_vld_i     (iss_vld_q),
        .a_i          (iss_a_q),
        .b_i          (iss_b_q),
        .result_vld_o (sub_res_vld),
        .result_o     (sub_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SUB_LATENCY; s++) tag_q[s] <= '0;
        end else begin
            tag_q[0] <= {iss_vld_q, iss_id_q};
            for (int s = 1; s < SUB_LATENCY; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    assign tag_tail = tag_q[SUB_LATENCY-1];

    // Routing relies only on the tag: the subtractor valid may be stale after rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld_q <= '0;
            rsp_res_q <= '0;
        end else if (tag_tail.vld) begin
            rsp_vld_q <= NUM_REQ'(1) << tag_tail.id;
            rsp_res_q <= sub_res;
        end else begin
            rsp_vld_q <= '0;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (req_gnt[i] && !rsp_vld_q[i] && cnt_q[i] < CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (!req_gnt[i] && rsp_vld_q[i] && cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Stale subtractor valids drain within SUB_LATENCY cycles of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            arm_q <= '0;
            err_q <= 1'b0;
        end else if (arm_q != ARM_W'(SUB_LATENCY)) begin
            arm_q <= arm_q + 1'b1;
        end else if (sub_res_vld != tag_tail.vld) begin
            err_q <= 1'b1;
        end
    end

    always_comb begin
        busy_w = iss_vld_q;
        for (int s = 0; s < SUB_LATENCY; s++) busy_w = busy_w | tag_q[s].vld;
        for (int i = 0; i < NUM_REQ; i++)     busy_w = busy_w | (cnt_q[i] != '0);
    end

    assign rsp_vld    = rsp_vld_q;
    assign rsp_result = rsp_res_q;
    assign busy       = busy_w;
    assign err_tag    = err_q;

endmodule
`default_nettype wire
